// File: rtl/multi_guess_pkg.sv
// rtl/multi_guess_pkg.sv - shared state encoding and width helper for the multi-guess scorer
package multi_guess_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCEPT = 3'd1,
        EVAL   = 3'd2,
        UPDATE = 3'd3,
        DONE   = 3'd4
    } state_e;

    // $clog2 with a floor of 1 so that degenerate parameters never produce zero-width buses
    function automatic int clog2_min1(input int value);
        int r;
        r = $clog2(value);
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/multi_guess_scorer_if.sv
// rtl/multi_guess_scorer_if.sv - round input handshake and result bus of the multi-guess scorer
// slave  : scorer side (takes start/in_valid/guesses/target, drives all results)
// master : game logic / display side
interface multi_guess_scorer_if
    import multi_guess_pkg::*;
#(
    parameter int N      = 8,
    parameter int M      = 4,
    parameter int ROUNDS = 5
) ();
    localparam int SW = clog2_min1(ROUNDS + 1);
    localparam int RW = clog2_min1(ROUNDS);

    logic                start;
    logic                in_valid;
    logic                in_ready;
    logic [M*N-1:0]      guesses;
    logic [N-1:0]        target;
    logic [M-1:0]        exact;
    logic [M-1:0]        lead_mask;
    logic                round_valid;
    logic [RW-1:0]       round_idx;
    logic [M*ROUNDS-1:0] history;
    logic [M*SW-1:0]     scores;
    logic                game_done;
    logic [M-1:0]        winner_mask;
    logic                busy;

    modport slave (
        input  start, in_valid, guesses, target,
        output in_ready, exact, lead_mask, round_valid, round_idx,
               history, scores, game_done, winner_mask, busy
    );

    modport master (
        output start, in_valid, guesses, target,
        input  in_ready, exact, lead_mask, round_valid, round_idx,
               history, scores, game_done, winner_mask, busy
    );
endinterface

// File: rtl/match_counter.sv
// rtl/match_counter.sv - combinational count of bit positions where guess equals target
// guess/target : N-bit operands
// count        : number of equal bit positions, 0..N
module match_counter
    import multi_guess_pkg::*;
#(
    parameter int N = 8,
    localparam int CW = clog2_min1(N + 1)
) (
    input  logic [N-1:0]  guess,
    input  logic [N-1:0]  target,
    output logic [CW-1:0] count
);
    always_comb begin
        count = '0;
        for (int i = 0; i < N; i++) begin
            count = count + CW'(guess[i] == target[i]);
        end
    end
endmodule

// File: rtl/multi_guess_scorer.sv
// rtl/multi_guess_scorer.sv - round-based M-player bit-guess scorer with per-game winner
// clk/reset : clock, synchronous active-high reset
// bus       : slave side of multi_guess_scorer_if (round handshake in, round/game results out)
module multi_guess_scorer
    import multi_guess_pkg::*;
#(
    parameter int N      = 8,
    parameter int M      = 4,
    parameter int ROUNDS = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    multi_guess_scorer_if.slave  bus
);
    localparam int CW = clog2_min1(N + 1);
    localparam int SW = clog2_min1(ROUNDS + 1);
    localparam int RW = clog2_min1(ROUNDS);

    state_e              state_q, state_d;
    logic [M*N-1:0]      guesses_q, guesses_d;
    logic [N-1:0]        target_q, target_d;
    logic [RW-1:0]       round_cnt_q, round_cnt_d;
    logic [M-1:0]        exact_q, exact_d;
    logic [M-1:0]        lead_q, lead_d;
    logic [M-1:0]        winner_q, winner_d;
    logic                round_valid_q, round_valid_d;
    logic                game_done_q, game_done_d;
    logic [RW-1:0]       round_idx_q, round_idx_d;
    logic [M*ROUNDS-1:0] history_q, history_d;
    logic [M*SW-1:0]     scores_q, scores_d;

    logic [CW-1:0]       corr [M];
    logic [M-1:0]        exact_new;
    logic [M-1:0]        lead_new;
    logic [M-1:0]        winner_new;
    logic [M*SW-1:0]     scores_inc;
    logic [M*ROUNDS-1:0] history_shift;

    for (genvar p = 0; p < M; p++) begin : g_match
        match_counter #(.N(N)) u_match (
            .guess  (guesses_q[p*N +: N]),
            .target (target_q),
            .count  (corr[p])
        );
    end

    // Round evaluation from the captured registers: maximum correlation, then masks.
    always_comb begin
        logic [CW-1:0] max_corr;
        max_corr  = '0;
        exact_new = '0;
        lead_new  = '0;
        for (int p = 0; p < M; p++) begin
            if (corr[p] > max_corr) max_corr = corr[p];
        end
        for (int p = 0; p < M; p++) begin
            exact_new[p] = (corr[p] == CW'(N));
            lead_new[p]  = (corr[p] == max_corr);
        end
    end

    always_comb begin
        scores_inc = scores_q;
        for (int p = 0; p < M; p++) begin
            scores_inc[p*SW +: SW] = scores_q[p*SW +: SW] + SW'(lead_new[p]);
        end
        // Shift-then-overwrite keeps this legal when ROUNDS == 1.
        history_shift         = history_q << M;
        history_shift[M-1:0]  = lead_new;
    end

    always_comb begin
        logic [SW-1:0] max_score;
        max_score  = '0;
        winner_new = '0;
        for (int p = 0; p < M; p++) begin
            if (scores_q[p*SW +: SW] > max_score) max_score = scores_q[p*SW +: SW];
        end
        for (int p = 0; p < M; p++) begin
            winner_new[p] = (scores_q[p*SW +: SW] == max_score);
        end
    end

    always_comb begin
        state_d       = state_q;
        guesses_d     = guesses_q;
        target_d      = target_q;
        round_cnt_d   = round_cnt_q;
        exact_d       = exact_q;
        lead_d        = lead_q;
        winner_d      = winner_q;
        round_valid_d = 1'b0;
        game_done_d   = 1'b0;
        round_idx_d   = round_idx_q;
        history_d     = history_q;
        scores_d      = scores_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d     = ACCEPT;
                    scores_d    = '0;
                    history_d   = '0;
                    round_cnt_d = '0;
                    winner_d    = '0;
                end
            end
            ACCEPT: begin
                if (bus.in_valid) begin
                    guesses_d = bus.guesses;
                    target_d  = bus.target;
                    state_d   = EVAL;
                end
            end
            EVAL: begin
                // Round results land on the EVAL->UPDATE edge so that exact, lead_mask,
                // scores and history are all visible during UPDATE alongside round_valid.
                exact_d       = exact_new;
                lead_d        = lead_new;
                round_valid_d = 1'b1;
                round_idx_d   = round_cnt_q;
                scores_d      = scores_inc;
                history_d     = history_shift;
                state_d       = UPDATE;
            end
            UPDATE: begin
                if (round_cnt_q == RW'(ROUNDS - 1)) begin
                    game_done_d = 1'b1;
                    winner_d    = winner_new;
                    state_d     = DONE;
                end else begin
                    round_cnt_d = round_cnt_q + RW'(1);
                    state_d     = ACCEPT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            guesses_q     <= '0;
            target_q      <= '0;
            round_cnt_q   <= '0;
            exact_q       <= '0;
            lead_q        <= '0;
            winner_q      <= '0;
            round_valid_q <= 1'b0;
            game_done_q   <= 1'b0;
            round_idx_q   <= '0;
            history_q     <= '0;
            scores_q      <= '0;
        end else begin
            state_q       <= state_d;
            guesses_q     <= guesses_d;
            target_q      <= target_d;
            round_cnt_q   <= round_cnt_d;
            exact_q       <= exact_d;
            lead_q        <= lead_d;
            winner_q      <= winner_d;
            round_valid_q <= round_valid_d;
            game_done_q   <= game_done_d;
            round_idx_q   <= round_idx_d;
            history_q     <= history_d;
            scores_q      <= scores_d;
        end
    end

    assign bus.in_ready    = (state_q == ACCEPT);
    assign bus.busy        = (state_q != IDLE);
    assign bus.exact       = exact_q;
    assign bus.lead_mask   = lead_q;
    assign bus.round_valid = round_valid_q;
    assign bus.round_idx   = round_idx_q;
    assign bus.history     = history_q;
    assign bus.scores      = scores_q;
    assign bus.game_done   = game_done_q;
    assign bus.winner_mask = winner_q;
endmodule
